// File: rtl/dut_io_pack.sv
// Bridges a 32-bit word stream to a wide DUT input vector and streams a wide
// DUT output vector back out as 32-bit words.
module dut_io_pack #(
  parameter int unsigned DUT_INPUT_WIDTH  = 256,
  parameter int unsigned DUT_OUTPUT_WIDTH = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 in_word_data,
  input  logic                        in_word_valid,
  output logic                        in_word_ready,
  input  logic                        in_clear,
  output logic [DUT_INPUT_WIDTH-1:0]  dut_input_vec,
  output logic                        dut_input_valid,
  input  logic [DUT_OUTPUT_WIDTH-1:0] dut_output_vec,
  input  logic                        capture,
  output logic [31:0]                 out_word_data,
  output logic                        out_word_valid,
  input  logic                        out_word_ready,
  output logic                        out_word_last,
  output logic                        capture_overrun
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NI     = (DUT_INPUT_WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned NO     = (DUT_OUTPUT_WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned IW     = (NI > 1) ? $clog2(NI) : 1;
  localparam int unsigned OW     = (NO > 1) ? $clog2(NO) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // ---------------- input path ----------------
  logic [NI-1:0][WORD_W-1:0] in_buf_q;
  logic [NI-1:0][WORD_W-1:0] in_asm_c;
  logic [NI*WORD_W-1:0]      in_flat_c;
  logic [IW-1:0]             in_idx_q;
  logic                      in_hs_c;
  logic                      in_last_c;

  assign in_hs_c   = in_word_valid && in_word_ready && !in_clear;
  assign in_last_c = (in_idx_q == IW'(NI - 1));
  assign in_flat_c = in_asm_c;

  // Assembly buffer with the offered word merged into its lane
  always_comb begin
    in_asm_c           = in_buf_q;
    in_asm_c[in_idx_q] = in_word_data;
  end

  // Word assembly; the full vector is published only when the last lane lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_word_ready   <= 1'b0;
      in_idx_q        <= '0;
      in_buf_q        <= '0;
      dut_input_vec   <= '0;
      dut_input_valid <= 1'b0;
    end else begin
      in_word_ready   <= 1'b1;
      dut_input_valid <= 1'b0;
      if (in_clear) begin
        in_idx_q <= '0;
      end else if (in_hs_c) begin
        in_buf_q <= in_asm_c;
        if (in_last_c) begin
          in_idx_q        <= '0;
          dut_input_vec   <= in_flat_c[DUT_INPUT_WIDTH-1:0];
          dut_input_valid <= 1'b1;
        end else begin
          in_idx_q <= in_idx_q + IW'(1);
        end
      end
    end
  end

  // ---------------- output path ----------------
  logic [0:0]                state_q, state_d;
  logic [NO-1:0][WORD_W-1:0] out_buf_q, out_buf_d;
  logic [NO-1:0][WORD_W-1:0] cap_c;
  logic [OW-1:0]             out_idx_q, out_idx_d;
  logic [OW-1:0]             out_nidx_c;
  logic [31:0]               out_data_d;
  logic                      out_valid_d;
  logic                      out_last_d;
  logic                      overrun_d;

  assign cap_c      = (NO*WORD_W)'(dut_output_vec);
  assign out_nidx_c = out_idx_q + OW'(1);

  // Output FSM registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      out_buf_q       <= '0;
      out_idx_q       <= '0;
      out_word_data   <= '0;
      out_word_valid  <= 1'b0;
      out_word_last   <= 1'b0;
      capture_overrun <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_buf_q       <= out_buf_d;
      out_idx_q       <= out_idx_d;
      out_word_data   <= out_data_d;
      out_word_valid  <= out_valid_d;
      out_word_last   <= out_last_d;
      capture_overrun <= overrun_d;
    end
  end

  // Output FSM next state: snapshot on capture, then walk lanes on each handshake
  always_comb begin
    state_d     = state_q;
    out_buf_d   = out_buf_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_word_data;
    out_valid_d = out_word_valid;
    out_last_d  = out_word_last;
    overrun_d   = capture_overrun;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          out_buf_d   = cap_c;
          out_idx_d   = '0;
          out_data_d  = cap_c[0];
          out_valid_d = 1'b1;
          out_last_d  = (NO == 1);
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (capture) begin
          overrun_d = 1'b1;
        end
        if (out_word_ready) begin
          if (out_word_last) begin
            out_idx_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_idx_d  = out_nidx_c;
            out_data_d = out_buf_q[out_nidx_c];
            out_last_d = (out_nidx_c == OW'(NO - 1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dut_io_pack.sv
// Bench for dut_io_pack: default instance (256/256) and a narrow instance (40/72).
module tb_dut_io_pack;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: default widths
  logic [31:0]  in_data_a;
  logic         in_valid_a, in_ready_a, in_clear_a;
  logic [255:0] din_vec_a;
  logic         din_valid_a;
  logic [255:0] dout_vec_a;
  logic         capture_a;
  logic [31:0]  out_data_a;
  logic         out_valid_a, out_ready_a, out_last_a, overrun_a;

  // instance B: 40-bit input vector, 72-bit output vector
  logic [31:0]  in_data_b;
  logic         in_valid_b, in_ready_b, in_clear_b;
  logic [39:0]  din_vec_b;
  logic         din_valid_b;
  logic [71:0]  dout_vec_b;
  logic         capture_b;
  logic [31:0]  out_data_b;
  logic         out_valid_b, out_ready_b, out_last_b, overrun_b;

  dut_io_pack u_a (
    .clk(clk), .reset(reset),
    .in_word_data(in_data_a), .in_word_valid(in_valid_a), .in_word_ready(in_ready_a),
    .in_clear(in_clear_a), .dut_input_vec(din_vec_a), .dut_input_valid(din_valid_a),
    .dut_output_vec(dout_vec_a), .capture(capture_a),
    .out_word_data(out_data_a), .out_word_valid(out_valid_a), .out_word_ready(out_ready_a),
    .out_word_last(out_last_a), .capture_overrun(overrun_a)
  );

  dut_io_pack #(.DUT_INPUT_WIDTH(40), .DUT_OUTPUT_WIDTH(72)) u_b (
    .clk(clk), .reset(reset),
    .in_word_data(in_data_b), .in_word_valid(in_valid_b), .in_word_ready(in_ready_b),
    .in_clear(in_clear_b), .dut_input_vec(din_vec_b), .dut_input_valid(din_valid_b),
    .dut_output_vec(dout_vec_b), .capture(capture_b),
    .out_word_data(out_data_b), .out_word_valid(out_valid_b), .out_word_ready(out_ready_b),
    .out_word_last(out_last_b), .capture_overrun(overrun_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [31:0] data;
    logic        exp_valid;
    logic [39:0] exp_vec;
  } in_vec_t;

  // reference model state, index 0 = A, 1 = B
  int           ni [2] = '{8, 2};
  int           no [2] = '{8, 3};
  int           iwd[2] = '{256, 40};
  int           icnt[2];
  logic [31:0]  iwords[2][8];
  logic [255:0] ivec_exp[2];
  logic         ipulse_exp[2];
  logic [31:0]  oq0[$];
  logic [31:0]  oq1[$];
  logic         ovr_exp[2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_data_a = '0; in_valid_a = 1'b0; in_clear_a = 1'b0; capture_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; in_clear_b = 1'b0; capture_b = 1'b0; out_ready_b = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      icnt[k] = 0; ivec_exp[k] = '0; ipulse_exp[k] = 1'b0; ovr_exp[k] = 1'b0;
    end
    oq0.delete();
    oq1.delete();
  endtask

  // Model step for the edge about to happen
  task automatic model_pre(input int k, input logic clr, input logic vld, input logic [31:0] data,
                           input logic cap, input logic [255:0] dvec, input logic rdy);
    logic [255:0] v;
    int busy;
    ipulse_exp[k] = 1'b0;
    if (clr) begin
      icnt[k] = 0;
    end else if (vld) begin
      iwords[k][icnt[k]] = data;
      icnt[k]++;
      if (icnt[k] == ni[k]) begin
        v = '0;
        for (int i = 0; i < ni[k]; i++) v = v | (256'(iwords[k][i]) << (32 * i));
        if (iwd[k] < 256) v = v & ((256'(1) << iwd[k]) - 256'(1));
        ivec_exp[k]   = v;
        ipulse_exp[k] = 1'b1;
        icnt[k]       = 0;
      end
    end
    busy = (k == 0) ? oq0.size() : oq1.size();
    if (cap) begin
      if (busy > 0) ovr_exp[k] = 1'b1;
      else for (int i = 0; i < no[k]; i++) begin
        if (k == 0) oq0.push_back(dvec[32*i +: 32]);
        else        oq1.push_back(dvec[32*i +: 32]);
      end
    end
    if (busy > 0 && rdy) begin
      if (k == 0) void'(oq0.pop_front());
      else        void'(oq1.pop_front());
    end
  endtask

  // Compare DUT outputs after the edge with the model
  task automatic model_post(input int k);
    logic [255:0] vec;
    logic pulse, rdy, ov, ol, ovr;
    logic [31:0] od;
    int sz;
    logic [31:0] head;
    if (k == 0) begin
      vec = din_vec_a; pulse = din_valid_a; rdy = in_ready_a;
      ov = out_valid_a; ol = out_last_a; od = out_data_a; ovr = overrun_a;
      sz = oq0.size(); head = (sz > 0) ? oq0[0] : 32'h0;
    end else begin
      vec = 256'(din_vec_b); pulse = din_valid_b; rdy = in_ready_b;
      ov = out_valid_b; ol = out_last_b; od = out_data_b; ovr = overrun_b;
      sz = oq1.size(); head = (sz > 0) ? oq1[0] : 32'h0;
    end
    chk($sformatf("rnd_in_ready%0d", k), 256'(rdy), 256'(1'b1));
    chk($sformatf("rnd_in_valid%0d", k), 256'(pulse), 256'(ipulse_exp[k]));
    chk($sformatf("rnd_in_vec%0d", k), vec, ivec_exp[k]);
    chk($sformatf("rnd_out_valid%0d", k), 256'(ov), 256'(sz > 0));
    chk($sformatf("rnd_overrun%0d", k), 256'(ovr), 256'(ovr_exp[k]));
    if (sz > 0) begin
      chk($sformatf("rnd_out_data%0d", k), 256'(od), 256'(head));
      chk($sformatf("rnd_out_last%0d", k), 256'(ol), 256'(sz == 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    in_vec_t tbl[9];
    logic [31:0] exp_b[3];
    logic [31:0] exp_a[8];
    int idx, budget, pulses;

    tbl[0] = '{1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 40'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h000000FF, 1'b1, 40'hFF_AAAAAAAA};
    tbl[2] = '{1'b0, 1'b0, 32'h12345678, 1'b0, 40'hFF_AAAAAAAA};
    tbl[3] = '{1'b0, 1'b1, 32'h11111111, 1'b0, 40'hFF_AAAAAAAA};
    tbl[4] = '{1'b1, 1'b1, 32'h22222222, 1'b0, 40'hFF_AAAAAAAA};
    tbl[5] = '{1'b0, 1'b1, 32'h33333333, 1'b0, 40'hFF_AAAAAAAA};
    tbl[6] = '{1'b0, 1'b1, 32'h00000044, 1'b1, 40'h44_33333333};
    tbl[7] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 40'h44_33333333};
    tbl[8] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 40'h44_33333333};

    // reset values
    idle_inputs();
    dout_vec_a = '0;
    dout_vec_b = '0;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_in_vec_a", din_vec_a, 256'h0);
    chk("rst_in_valid_a", 256'(din_valid_a), 256'h0);
    chk("rst_out_valid_a", 256'(out_valid_a), 256'h0);
    chk("rst_out_last_a", 256'(out_last_a), 256'h0);
    chk("rst_out_data_a", 256'(out_data_a), 256'h0);
    chk("rst_overrun_a", 256'(overrun_a), 256'h0);
    chk("rst_in_vec_b", 256'(din_vec_b), 256'h0);
    chk("rst_out_valid_b", 256'(out_valid_b), 256'h0);
    reset = 1'b1;
    tick();
    chk("ready_after_reset_a", 256'(in_ready_a), 256'h1);
    chk("ready_after_reset_b", 256'(in_ready_b), 256'h1);

    // table: 40-bit input assembly with clears
    for (int i = 0; i < 9; i++) begin
      in_clear_b = tbl[i].clr;
      in_valid_b = tbl[i].vld;
      in_data_b  = tbl[i].data;
      tick();
      chk($sformatf("tbl%0d_valid", i), 256'(din_valid_b), 256'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_vec", i), 256'(din_vec_b), 256'(tbl[i].exp_vec));
    end
    idle_inputs();

    // 8 back-to-back words 0..7
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 32'(i);
      tick();
      chk($sformatf("fill8_pulse%0d", i), 256'(din_valid_a), 256'(i == 7));
    end
    in_valid_a = 1'b0;
    chk("fill8_lsw", 256'(din_vec_a[31:0]), 256'h0);
    chk("fill8_msw", 256'(din_vec_a[255:224]), 256'h7);
    tick();
    chk("fill8_pulse_end", 256'(din_valid_a), 256'h0);

    // 3 words, clear (with dropped word), then 8 words 0x10..0x17
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid_a = 1'b1;
      in_clear_a = (i == 3);
      in_data_a  = (i < 3) ? 32'hE0 + 32'(i) : (i == 3) ? 32'hDEAD : 32'h10 + 32'(i - 4);
      tick();
      if (din_valid_a) pulses++;
    end
    idle_inputs();
    tick();
    if (din_valid_a) pulses++;
    chk("clear_pulses", 256'(pulses), 256'h1);
    chk("clear_lsw", 256'(din_vec_a[31:0]), 256'h10);
    chk("clear_w1", 256'(din_vec_a[63:32]), 256'h11);
    chk("clear_msw", 256'(din_vec_a[255:224]), 256'h17);

    // 72-bit capture with toggling ready
    exp_b = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'h000000CC};
    dout_vec_b = 72'hCC_BBBBBBBB_AAAAAAAA;
    capture_b  = 1'b1;
    tick();
    capture_b  = 1'b0;
    dout_vec_b = 72'h11_22222222_33333333;
    idx = 0;
    budget = 0;
    while (idx < 3 && budget < 20) begin
      chk($sformatf("b_valid_c%0d", budget), 256'(out_valid_b), 256'h1);
      chk($sformatf("b_data_c%0d", budget), 256'(out_data_b), 256'(exp_b[idx]));
      chk($sformatf("b_last_c%0d", budget), 256'(out_last_b), 256'(idx == 2));
      out_ready_b = budget[0];
      tick();
      if (out_ready_b) idx++;
      budget++;
    end
    out_ready_b = 1'b0;
    chk("b_stream_done", 256'(idx), 256'h3);
    chk("b_idle_after", 256'(out_valid_b), 256'h0);
    chk("b_no_overrun", 256'(overrun_b), 256'h0);

    // capture during SEND, including on the last handshake
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 32'h10000000 + 32'(i) * 32'h01010101;
      dout_vec_a[32*i +: 32] = exp_a[i];
    end
    capture_a = 1'b1;
    tick();
    capture_a = 1'b0;
    out_ready_a = 1'b1;
    chk("a_overrun_before", 256'(overrun_a), 256'h0);
    idx = 0;
    budget = 0;
    while (idx < 8 && budget < 20) begin
      chk($sformatf("a_valid%0d", idx), 256'(out_valid_a), 256'h1);
      chk($sformatf("a_data%0d", idx), 256'(out_data_a), 256'(exp_a[idx]));
      chk($sformatf("a_last%0d", idx), 256'(out_last_a), 256'(idx == 7));
      capture_a  = (idx == 3 || idx == 7);
      dout_vec_a = ~dout_vec_a;
      tick();
      idx++;
      budget++;
    end
    capture_a = 1'b0;
    out_ready_a = 1'b0;
    chk("a_stream_done", 256'(idx), 256'h8);
    chk("a_idle_after", 256'(out_valid_a), 256'h0);
    chk("a_overrun", 256'(overrun_a), 256'h1);
    tick();
    chk("a_overrun_sticky", 256'(overrun_a), 256'h1);

    // reset in the middle of a send
    dout_vec_b = 72'h01_02020202_03030303;
    capture_b  = 1'b1;
    tick();
    capture_b  = 1'b0;
    tick();
    chk("mid_valid_before", 256'(out_valid_b), 256'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(out_valid_b), 256'h0);
    chk("mid_rst_data", 256'(out_data_b), 256'h0);
    chk("mid_rst_overrun_a", 256'(overrun_a), 256'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_post_valid", 256'(out_valid_b), 256'h0);
    dout_vec_b = 72'h77_66666666_55555555;
    capture_b  = 1'b1;
    tick();
    capture_b  = 1'b0;
    chk("mid_restart_valid", 256'(out_valid_b), 256'h1);
    chk("mid_restart_data", 256'(out_data_b), 256'h55555555);
    chk("mid_restart_last", 256'(out_last_b), 256'h0);

    // randomized traffic against the model, both paths active together
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid_a  = ($urandom_range(0, 9) < 7);
      in_data_a   = $urandom;
      in_clear_a  = ($urandom_range(0, 15) == 0);
      capture_a   = ($urandom_range(0, 7) == 0);
      out_ready_a = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 8; i++) dout_vec_a[32*i +: 32] = $urandom;
      in_valid_b  = ($urandom_range(0, 9) < 7);
      in_data_b   = $urandom;
      in_clear_b  = ($urandom_range(0, 15) == 0);
      capture_b   = ($urandom_range(0, 5) == 0);
      out_ready_b = $urandom_range(0, 1) == 1;
      dout_vec_b  = {8'($urandom), 32'($urandom), 32'($urandom)};
      model_pre(0, in_clear_a, in_valid_a, in_data_a, capture_a, dout_vec_a, out_ready_a);
      model_pre(1, in_clear_b, in_valid_b, in_data_b, capture_b, 256'(dout_vec_b), out_ready_b);
      tick();
      model_post(0);
      model_post(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
